// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, funct codes,
// ALU operation codes, mux selects, FSM states and the per-state output table.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BEQ = 4'b1000;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_EXEC_R, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP, S_ILLEGAL
    } state_t;

    // fetch/branch/jump flag the states whose PCWrite/IRWrite are gated by live inputs
    typedef struct packed {
        logic [3:0] alu_control;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       illegal;
        logic       fetch;
        logic       branch;
        logic       jump;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(state_t s, logic [3:0] r_alu);
        ctrl_t c;
        c = '0;
        c.alu_control = ALU_ADD;
        case (s)
            S_IDLE:      c = '0;
            S_FETCH:     begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; c.pc_source = PCSRC_ALU; c.fetch = 1'b1; end
            S_DECODE:    c.alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEM_READ:  begin c.iord = 1'b1; c.mem_read = 1'b1; end
            S_MEM_WB:    begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
            S_MEM_WRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_EXEC_R:    begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_control = r_alu; end
            S_R_WB:      begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_control = r_alu; end
            S_ADDI_WB:   c.reg_write = 1'b1;
            S_BRANCH:    begin c.alu_src_a = 1'b1; c.alu_control = ALU_SUB; c.pc_source = PCSRC_ALUOUT; c.branch = 1'b1; end
            S_JUMP:      begin c.pc_source = PCSRC_JUMP; c.jump = 1'b1; end
            S_ILLEGAL:   c.illegal = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit to datapath bundle: IR fields and status in, enables and selects out.
interface mips_multicycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       ZF;
    logic       MemReady;
    logic [3:0] ALU_Control;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       Illegal;

    modport master (
        input  Opcode, Funct, ZF, MemReady,
        output ALU_Control, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, Illegal
    );

    modport slave (
        output Opcode, Funct, ZF, MemReady,
        input  ALU_Control, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst,
               MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSource, Illegal
    );
endinterface

// File: rtl/mips_multicycle_control_alu_funct_decoder.sv
// R-type funct field to ALU operation code; valid is low for unsupported functs.
module alu_funct_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       valid
);
    always_comb begin
        alu_control = ALU_ADD;
        valid       = 1'b1;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            FN_SLT:  alu_control = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM sequencing fetch/decode/execute/memory/write-back for the MIPS datapath.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    mips_multicycle_control_if.master bus
);
    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl;
    logic       armed;
    logic [3:0] r_alu;
    logic       r_valid;

    alu_funct_decoder u_funct_dec (
        .funct       (bus.Funct),
        .alu_control (r_alu),
        .valid       (r_valid)
    );

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      state_next = armed ? S_FETCH : S_IDLE;
            S_FETCH:     state_next = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Opcode)
                    OP_RTYPE:             state_next = S_EXEC_R;
                    OP_LW, OP_SW, OP_ADDI: state_next = S_MEM_ADDR;
                    OP_BEQ:               state_next = S_BRANCH;
                    OP_J:                 state_next = S_JUMP;
                    default:              state_next = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                case (bus.Opcode)
                    OP_LW:   state_next = S_MEM_READ;
                    OP_SW:   state_next = S_MEM_WRITE;
                    default: state_next = S_ADDI_WB;
                endcase
            end
            S_MEM_READ:  state_next = bus.MemReady ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_next = bus.MemReady ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R:    state_next = r_valid ? S_R_WB : S_ILLEGAL;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP, S_ILLEGAL: state_next = S_FETCH;
            default:     state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they track the state register
    // exactly; armed holds IDLE for one extra cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            ctrl  <= '0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            state <= state_next;
            ctrl  <= ctrl_for(state_next, r_alu);
        end
    end

    assign bus.ALU_Control = ctrl.alu_control;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.Illegal     = ctrl.illegal;
    assign bus.IRWrite     = ctrl.fetch & bus.MemReady;
    assign bus.PCWrite     = (ctrl.fetch & bus.MemReady) | (ctrl.branch & bus.ZF) | ctrl.jump;
endmodule
